// File: rtl/wb_car_ctrl_master.sv
// Wishbone initiator that steps the player car from the left/right buttons and
// mirrors it into the VGA display slave's register file. No CPU is involved.
//
// On every POLL_DIV-cycle tick the synchronised buttons are sampled. If the
// clamped next column differs from the committed one, reg0 is written with it.
// reg1 is then read back and its two low bits become the level. A bus error,
// or TIMEOUT cycles without a termination, aborts the cycle and sets a sticky
// error flag.
//
// Ports:
//   wb_clk_i, wb_rst_ni         bus clock, asynchronous active-low reset
//   btn_left_i, btn_right_i     raw asynchronous buttons, active-high
//   wbm_cyc_o .. wbm_sel_o      registered Wishbone request outputs
//   wbm_dat_i, wbm_ack_i,
//   wbm_err_i                   Wishbone response inputs
//   car_x_o                     committed car column
//   level_o                     last level read from reg1[1:0]
//   bus_err_o                   sticky abort flag
module wb_car_ctrl_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [19:0] POLL_DIV  = 20'd500000,
  parameter logic [9:0]  STEP      = 10'd4,
  parameter logic [9:0]  X_MIN     = 10'd160,
  parameter logic [9:0]  X_MAX     = 10'd448,
  parameter logic [9:0]  X_INIT    = 10'd305,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [9:0]  car_x_o,
  output logic [1:0]  level_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {StIdle, StWr, StGap, StRd} state_e;

  state_e      state_q;
  logic [1:0]  left_sync_q, right_sync_q;
  logic [19:0] tick_cnt_q;
  logic        tick;
  logic [7:0]  wait_q;
  logic [9:0]  nx_q;
  logic [9:0]  next_x;
  logic [10:0] x_plus;

  // Only reg1[1:0] carries the level.
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i[31:2];

  // Button synchronisers and the free-running tick divider.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      left_sync_q  <= 2'b00;
      right_sync_q <= 2'b00;
      tick_cnt_q   <= '0;
    end else begin
      left_sync_q  <= {left_sync_q[0], btn_left_i};
      right_sync_q <= {right_sync_q[0], btn_right_i};
      tick_cnt_q   <= tick ? '0 : tick_cnt_q + 20'd1;
    end
  end

  assign tick = (tick_cnt_q == POLL_DIV - 20'd1);

  // Clamped next column. The comparisons use 11 bits so that neither the
  // subtraction nor the addition can wrap.
  assign x_plus = {1'b0, car_x_o} + {1'b0, STEP};

  always_comb begin
    next_x = car_x_o;
    if (left_sync_q[1] && !right_sync_q[1]) begin
      if ({1'b0, car_x_o} >= ({1'b0, X_MIN} + {1'b0, STEP})) next_x = car_x_o - STEP;
      else                                                   next_x = X_MIN;
    end else if (right_sync_q[1] && !left_sync_q[1]) begin
      if (x_plus > {1'b0, X_MAX}) next_x = X_MAX;
      else                        next_x = x_plus[9:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wait_q    <= '0;
      nx_q      <= X_INIT;
      car_x_o   <= X_INIT;
      level_o   <= 2'b00;
      bus_err_o <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Ticks arriving in any other state are dropped, not queued.
          if (tick) begin
            wait_q    <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            if (next_x != car_x_o) begin
              state_q   <= StWr;
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= BASE_ADDR;
              wbm_dat_o <= {22'b0, next_x};
              nx_q      <= next_x;
            end else begin
              state_q   <= StRd;
              wbm_we_o  <= 1'b0;
              wbm_adr_o <= BASE_ADDR + 32'd4;
            end
          end
        end
        StWr, StRd: begin
          // err wins over a simultaneous ack.
          if (wbm_err_i || (!wbm_ack_i && (wait_q == TIMEOUT - 8'd1))) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            bus_err_o <= 1'b1;
            state_q   <= StIdle;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            if (state_q == StWr) begin
              car_x_o <= nx_q;
              state_q <= StGap;
            end else begin
              level_o <= wbm_dat_i[1:0];
              state_q <= StIdle;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StGap: begin
          // One idle bus cycle separates the write from the read.
          wait_q    <= '0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= 1'b0;
          wbm_adr_o <= BASE_ADDR + 32'd4;
          wbm_sel_o <= 4'hF;
          state_q   <= StRd;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_car_ctrl_master.sv
module tb_wb_car_ctrl_master;

  localparam int PollDiv = 8;
  localparam int XMin    = 160;
  localparam int XMax    = 448;
  localparam int XInit   = 305;
  localparam int StepPx  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_l = 1'b0;
  logic        btn_r = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i;
  logic [9:0]  car_x_o;
  logic [1:0]  level_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  wb_car_ctrl_master #(
    .BASE_ADDR(32'h0000_0000),
    .POLL_DIV (20'd8),
    .STEP     (10'd4),
    .X_MIN    (10'd160),
    .X_MAX    (10'd448),
    .X_INIT   (10'd305),
    .TIMEOUT  (8'd255)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .btn_left_i (btn_l),
    .btn_right_i(btn_r),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .car_x_o    (car_x_o),
    .level_o    (level_o),
    .bus_err_o  (bus_err_o)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Display slave: terminates one cycle after it sees a request.
  // mode 0 = ack, 1 = err, 2 = never respond.
  int          mode = 0;
  logic [31:0] reg1 = 32'h0;
  assign wbm_dat_i = reg1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
    end else begin
      wbm_ack_i <= (mode == 0) && wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i;
      wbm_err_i <= (mode == 1) && wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i;
    end
  end

  // Reference model: car column and level as plain integers.
  int mx = XInit;
  int ml = 0;

  function automatic int model_next_x(input int x, input bit l, input bit r);
    if (l && !r) return (x - StepPx < XMin) ? XMin : x - StepPx;
    if (r && !l) return (x + StepPx > XMax) ? XMax : x + StepPx;
    return x;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  bit   mon_en = 1'b0;
  logic stb_prev = 1'b0;
  logic ack_prev = 1'b0;

  // Bus monitor: each new request must match the next expected one, and stb
  // must fall right after an ack.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ack_prev) check_eq("stb_drop_after_ack", 32'(wbm_stb_o), 32'(0));
      if (wbm_stb_o && !stb_prev) begin
        check_eq("req_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("req_we", 32'(wbm_we_o), 32'(mon_e.we));
          check_eq("req_adr", wbm_adr_o, mon_e.adr);
          check_eq("req_sel", 32'(wbm_sel_o), 32'hF);
          check_eq("req_cyc", 32'(wbm_cyc_o), 32'(1));
          if (mon_e.we) check_eq("req_wdat", wbm_dat_o, mon_e.dat);
        end
      end
    end
    stb_prev <= wbm_stb_o;
    ack_prev <= wbm_stb_o && wbm_ack_i;
  end

  // One tick period, entered on the negedge just after a tick edge.
  task automatic run_period(input bit l, input bit r);
    int nx;
    btn_l = l;
    btn_r = r;
    repeat (PollDiv - 1) @(negedge clk);
    check_eq("car_x", 32'(car_x_o), 32'(mx));
    check_eq("level", 32'(level_o), 32'(ml));
    check_eq("queue_drained", 32'(exp_q.size()), 32'(0));
    nx = model_next_x(mx, l, r);
    if (nx != mx) exp_q.push_back('{we: 1'b1, adr: 32'h0, dat: 32'(nx)});
    exp_q.push_back('{we: 1'b0, adr: 32'h4, dat: 32'h0});
    reg1 = $urandom;
    mx = nx;
    ml = int'(reg1[1:0]);
    @(negedge clk);
  endtask

  task automatic wait_stb(input logic level, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wbm_stb_o === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cyc"}, 32'(wbm_cyc_o), 32'(0));
    check_eq({tag, "_stb"}, 32'(wbm_stb_o), 32'(0));
    check_eq({tag, "_car_x"}, 32'(car_x_o), 32'(XInit));
    check_eq({tag, "_level"}, 32'(level_o), 32'(0));
    check_eq({tag, "_bus_err"}, 32'(bus_err_o), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    reg1 = $urandom;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check_eq("reset_we", 32'(wbm_we_o), 32'(0));
    check_eq("reset_adr", wbm_adr_o, 32'h0);
    check_eq("reset_dat", wbm_dat_o, 32'h0);
    check_eq("reset_sel", 32'(wbm_sel_o), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_period(1'b0, 1'b1);                  // 305 -> 309, write data 0x135
    repeat (4)  run_period(1'b0, 1'b0);
    repeat (45) run_period(1'b1, 1'b0);      // down to X_MIN, then reads only
    repeat (5)  run_period(1'b1, 1'b1);
    repeat (80) run_period(1'b0, 1'b1);      // up to X_MAX
    repeat (50) run_period(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (50) run_period(1'b1, 1'b0);      // park at X_MIN

    // Error termination on a write.
    btn_l = 1'b0;
    btn_r = 1'b1;
    repeat (PollDiv - 1) @(negedge clk);
    check_eq("pre_err_queue", 32'(exp_q.size()), 32'(0));
    mon_en = 1'b0;
    mode   = 1;
    wait_stb(1'b1, 20, ok);
    check_eq("err_req_seen", 32'(ok), 32'(1));
    check_eq("err_req_we", 32'(wbm_we_o), 32'(1));
    check_eq("err_req_dat", wbm_dat_o, 32'(mx + StepPx));
    wait_stb(1'b0, 20, ok);
    check_eq("err_req_end", 32'(ok), 32'(1));
    check_eq("err_bus_err", 32'(bus_err_o), 32'(1));
    check_eq("err_car_x", 32'(car_x_o), 32'(mx));

    // Silent slave: abort after the timeout.
    mode = 2;
    wait_stb(1'b1, 20, ok);
    check_eq("to_req_seen", 32'(ok), 32'(1));
    check_eq("to_req_dat", wbm_dat_o, 32'(mx + StepPx));
    cnt = 0;
    while (wbm_stb_o && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("to_stb_len", 32'(cnt), 32'(255));
    check_eq("to_bus_err", 32'(bus_err_o), 32'(1));
    check_eq("to_car_x", 32'(car_x_o), 32'(mx));
    check_eq("to_level", 32'(level_o), 32'(ml));

    // Next tick resumes with a fresh write.
    mode = 0;
    wait_stb(1'b1, 20, ok);
    check_eq("resume_seen", 32'(ok), 32'(1));
    check_eq("resume_we", 32'(wbm_we_o), 32'(1));
    check_eq("resume_dat", wbm_dat_o, 32'(mx + StepPx));

    // Reset in the middle of that write drops the bus at once.
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    mx = XInit;
    ml = 0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) run_period(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_period(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
